// File: rtl/spi_reg_pkg.sv
// Shared state encoding and constants for the SPI byte-side register controller.
package spi_reg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_RD_HOLD
   } state_e;

   localparam int         RW_BIT          = 7;
   localparam logic [7:0] TX_FILL_WRITE   = 8'h00;
   localparam logic [7:0] TX_FILL_TIMEOUT = 8'hEE;

endpackage

// File: rtl/spi_reg_controller_if.sv
// Byte-stream and register-bus signals between the SPI slave, the controller and the register file.
interface spi_reg_controller_if #(
   parameter int ADDR_WIDTH = 7
);
   logic [7:0]            rx_data;
   logic                  rx_data_strobe;
   logic                  rx_start;
   logic                  rx_end_strobe;
   logic                  tx_ready;
   logic [7:0]            tx_data;
   logic                  tx_data_strobe;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [7:0]            reg_wdata;
   logic                  reg_we;
   logic                  reg_re;
   logic [7:0]            reg_rdata;
   logic                  reg_rvalid;
   logic                  busy;
   logic                  err_timeout;

   // The controller drives the register bus and the slave tx buffer.
   modport master (
      input  rx_data, rx_data_strobe, rx_start, rx_end_strobe, tx_ready,
      input  reg_rdata, reg_rvalid,
      output tx_data, tx_data_strobe, reg_addr, reg_wdata, reg_we, reg_re,
      output busy, err_timeout
   );

   modport slave (
      output rx_data, rx_data_strobe, rx_start, rx_end_strobe, tx_ready,
      output reg_rdata, reg_rvalid,
      input  tx_data, tx_data_strobe, reg_addr, reg_wdata, reg_we, reg_re,
      input  busy, err_timeout
   );

endinterface

// File: rtl/spi_reg_controller.sv
// Splits each chip-select framed SPI transaction into a command byte plus data bytes and
// sequences register writes or prefetched reads, feeding read data back to the slave tx buffer.
module spi_reg_controller
   import spi_reg_pkg::*;
#(
   parameter int ADDR_WIDTH = 7,
   parameter int RD_TIMEOUT = 15
) (
   input  logic                 CLK_40,
   input  logic                 reset_n,
   spi_reg_controller_if.master bus
);

   localparam int               CNT_W   = $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_strobe_q, tx_strobe_d;
   logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]            reg_wdata_q, reg_wdata_d;
   logic                  reg_we_q, reg_we_d;
   logic                  reg_re_q, reg_re_d;
   logic                  busy_q, busy_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  cmd_strobe;

   // A start-flagged byte is a command in any state, recovering from a missed end strobe.
   assign cmd_strobe = bus.rx_data_strobe & bus.rx_start;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d       = state_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      tx_data_d     = tx_data_q;
      tx_strobe_d   = 1'b0;
      reg_addr_d    = reg_addr_q;
      reg_wdata_d   = reg_wdata_q;
      reg_we_d      = 1'b0;
      reg_re_d      = 1'b0;
      busy_d        = busy_q;
      err_timeout_d = err_timeout_q;

      if (bus.rx_end_strobe) begin
         // End of frame wins over a coincident byte and abandons any pending read.
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else if (cmd_strobe) begin
         addr_d = bus.rx_data[ADDR_WIDTH-1:0];
         busy_d = 1'b1;
         if (bus.rx_data[RW_BIT]) begin
            state_d = ST_RD_ISSUE;
         end else begin
            state_d     = ST_WRITE;
            tx_data_d   = TX_FILL_WRITE;
            tx_strobe_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_WRITE: begin
               if (bus.rx_data_strobe) begin
                  reg_we_d    = 1'b1;
                  reg_addr_d  = addr_q;
                  reg_wdata_d = bus.rx_data;
                  addr_d      = addr_q + 1'b1;
               end
            end
            ST_RD_ISSUE: begin
               reg_re_d   = 1'b1;
               reg_addr_d = addr_q;
               cnt_d      = '0;
               state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (bus.reg_rvalid) begin
                  tx_data_d   = bus.reg_rdata;
                  tx_strobe_d = 1'b1;
                  addr_d      = addr_q + 1'b1;
                  state_d     = ST_RD_HOLD;
               end else if (cnt_q == CNT_MAX) begin
                  tx_data_d     = TX_FILL_TIMEOUT;
                  tx_strobe_d   = 1'b1;
                  err_timeout_d = 1'b1;
                  addr_d        = addr_q + 1'b1;
                  state_d       = ST_RD_HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RD_HOLD: begin
               // Master bytes here are dummies; each one prefetches the next address.
               if (bus.rx_data_strobe) begin
                  state_d = ST_RD_ISSUE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK_40) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         cnt_q         <= '0;
         tx_data_q     <= '0;
         tx_strobe_q   <= 1'b0;
         reg_addr_q    <= '0;
         reg_wdata_q   <= '0;
         reg_we_q      <= 1'b0;
         reg_re_q      <= 1'b0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         tx_data_q     <= tx_data_d;
         tx_strobe_q   <= tx_strobe_d;
         reg_addr_q    <= reg_addr_d;
         reg_wdata_q   <= reg_wdata_d;
         reg_we_q      <= reg_we_d;
         reg_re_q      <= reg_re_d;
         busy_q        <= busy_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign bus.tx_data        = tx_data_q;
   assign bus.tx_data_strobe = tx_strobe_q;
   assign bus.reg_addr       = reg_addr_q;
   assign bus.reg_wdata      = reg_wdata_q;
   assign bus.reg_we         = reg_we_q;
   assign bus.reg_re         = reg_re_q;
   assign bus.busy           = busy_q;
   assign bus.err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller: cycle-exact write vectors from a table, plus
// hand-written read, timeout, abort and reset sequences against a small register model.
module tb_spi_reg_controller;

   localparam int AW = 7;
   localparam int TO = 15;

   typedef struct packed {
      logic [7:0]    tx_data;
      logic          tx_strobe;
      logic [AW-1:0] reg_addr;
      logic [7:0]    reg_wdata;
      logic          reg_we;
      logic          reg_re;
      logic          busy;
      logic          err;
   } outs_t;

   typedef struct {
      logic [7:0] rx_data;
      logic       strobe;
      logic       start;
      logic       stop;
      outs_t      exp;
   } vec_t;

   logic clk_40  = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_40 = ~clk_40;

   spi_reg_controller_if #(.ADDR_WIDTH(AW)) bus ();

   spi_reg_controller #(.ADDR_WIDTH(AW), .RD_TIMEOUT(TO)) dut (
      .CLK_40  (clk_40),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   int            re_cyc[$];
   logic [AW-1:0] re_addr[$];
   int            tx_cyc[$];
   logic [7:0]    tx_byte[$];

   logic [7:0] regs [128];
   bit         resp_en  = 1'b0;
   int         resp_lat = 2;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic outs_t sample();
      outs_t o;
      o.tx_data   = bus.tx_data;
      o.tx_strobe = bus.tx_data_strobe;
      o.reg_addr  = bus.reg_addr;
      o.reg_wdata = bus.reg_wdata;
      o.reg_we    = bus.reg_we;
      o.reg_re    = bus.reg_re;
      o.busy      = bus.busy;
      o.err       = bus.err_timeout;
      return o;
   endfunction

   function automatic vec_t mk(input logic [7:0] d, input logic s, input logic st, input logic e,
                               input logic [7:0] tx, input logic txs, input logic [AW-1:0] a,
                               input logic [7:0] wd, input logic we, input logic busy);
      vec_t v;
      v.rx_data = d;
      v.strobe  = s;
      v.start   = st;
      v.stop    = e;
      v.exp     = '{tx_data: tx, tx_strobe: txs, reg_addr: a, reg_wdata: wd,
                    reg_we: we, reg_re: 1'b0, busy: busy, err: 1'b0};
      return v;
   endfunction

   // Cycle counter and output monitor, sampled just after each rising edge.
   initial forever begin
      @(posedge clk_40);
      cyc++;
      #1;
      if (bus.reg_re) begin
         re_cyc.push_back(cyc);
         re_addr.push_back(bus.reg_addr);
      end
      if (bus.tx_data_strobe) begin
         tx_cyc.push_back(cyc);
         tx_byte.push_back(bus.tx_data);
      end
   end

   // Register file model: answers reg_re after resp_lat cycles.
   initial forever begin
      logic [AW-1:0] a;
      @(posedge clk_40);
      #1;
      if (bus.reg_re && resp_en) begin
         a = bus.reg_addr;
         repeat (resp_lat) @(posedge clk_40);
         #1;
         bus.reg_rvalid = 1'b1;
         bus.reg_rdata  = regs[a];
         @(posedge clk_40);
         #1;
         bus.reg_rvalid = 1'b0;
      end
   end

   task automatic clear_mon();
      re_cyc.delete();
      re_addr.delete();
      tx_cyc.delete();
      tx_byte.delete();
   endtask

   // Drive one byte strobe at a falling edge; returns the cycle it is sampled in.
   task automatic send(input logic [7:0] d, input logic st, output int s);
      @(negedge clk_40);
      s                  = cyc;
      bus.rx_data        = d;
      bus.rx_data_strobe = 1'b1;
      bus.rx_start       = st;
      @(negedge clk_40);
      bus.rx_data_strobe = 1'b0;
      bus.rx_start       = 1'b0;
   endtask

   task automatic end_frame();
      @(negedge clk_40);
      bus.rx_end_strobe = 1'b1;
      @(negedge clk_40);
      bus.rx_end_strobe = 1'b0;
   endtask

   initial begin
      int s;
      int s0;
      bus.rx_data        = '0;
      bus.rx_data_strobe = 1'b0;
      bus.rx_start       = 1'b0;
      bus.rx_end_strobe  = 1'b0;
      bus.tx_ready       = 1'b1;
      bus.reg_rdata      = '0;
      bus.reg_rvalid     = 1'b0;
      for (int i = 0; i < 128; i++) regs[i] = 8'(i ^ 8'h3C);
      regs[8'h10] = 8'hAB;
      regs[8'h11] = 8'hCD;
      regs[8'h12] = 8'h5A;
      regs[8'h13] = 8'h77;

      //            data   stb  st   end   tx     txs  addr   wdata  we   busy
      vecs.push_back(mk(8'h05, 1, 1, 0, 8'h00, 1, 7'h00, 8'h00, 0, 1));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 0, 7'h00, 8'h00, 0, 1));
      vecs.push_back(mk(8'h11, 1, 0, 0, 8'h00, 0, 7'h05, 8'h11, 1, 1));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 0, 7'h05, 8'h11, 0, 1));
      vecs.push_back(mk(8'h22, 1, 0, 0, 8'h00, 0, 7'h06, 8'h22, 1, 1));
      vecs.push_back(mk(8'h33, 1, 0, 0, 8'h00, 0, 7'h07, 8'h33, 1, 1));
      vecs.push_back(mk(8'h00, 0, 0, 1, 8'h00, 0, 7'h07, 8'h33, 0, 0));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 0, 7'h07, 8'h33, 0, 0));
      vecs.push_back(mk(8'h7F, 1, 1, 0, 8'h00, 1, 7'h07, 8'h33, 0, 1));
      vecs.push_back(mk(8'hAA, 1, 0, 0, 8'h00, 0, 7'h7F, 8'hAA, 1, 1));
      vecs.push_back(mk(8'hBB, 1, 0, 0, 8'h00, 0, 7'h00, 8'hBB, 1, 1));
      vecs.push_back(mk(8'hCC, 1, 0, 1, 8'h00, 0, 7'h00, 8'hBB, 0, 0));
      vecs.push_back(mk(8'hCC, 1, 0, 0, 8'h00, 0, 7'h00, 8'hBB, 0, 0));
      vecs.push_back(mk(8'h10, 1, 1, 0, 8'h00, 1, 7'h00, 8'hBB, 0, 1));
      vecs.push_back(mk(8'h20, 1, 1, 0, 8'h00, 1, 7'h00, 8'hBB, 0, 1));
      vecs.push_back(mk(8'h44, 1, 0, 0, 8'h00, 0, 7'h20, 8'h44, 1, 1));
      vecs.push_back(mk(8'h00, 0, 0, 1, 8'h00, 0, 7'h20, 8'h44, 0, 0));

      repeat (3) @(negedge clk_40);
      check("reset_state", 32'(sample()), 32'(outs_t'(0)));
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_40);
         bus.rx_data        = vecs[i].rx_data;
         bus.rx_data_strobe = vecs[i].strobe;
         bus.rx_start       = vecs[i].start;
         bus.rx_end_strobe  = vecs[i].stop;
         @(posedge clk_40);
         #1;
         check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
      end
      @(negedge clk_40);
      bus.rx_data_strobe = 1'b0;
      bus.rx_start       = 1'b0;
      bus.rx_end_strobe  = 1'b0;

      // Read burst, latency 2: cmd 0x90 then three dummy bytes.
      resp_en  = 1'b1;
      resp_lat = 2;
      clear_mon();
      send(8'h90, 1'b1, s0);
      for (int k = 0; k < 3; k++) begin
         repeat (8) @(negedge clk_40);
         send(8'h00, 1'b0, s);
      end
      repeat (8) @(negedge clk_40);
      end_frame();
      repeat (3) @(negedge clk_40);
      check("rd_re_count", 32'(re_cyc.size()), 32'd4);
      check("rd_re_latency", 32'(re_cyc[0] - s0), 32'd2);
      check("rd_tx_latency", 32'(tx_cyc[0] - re_cyc[0]), 32'd3);
      check("rd_addr0", 32'(re_addr[0]), 32'h10);
      check("rd_addr3", 32'(re_addr[3]), 32'h13);
      check("rd_miso_byte2", 32'(tx_byte[0]), 32'hAB);
      check("rd_miso_byte3", 32'(tx_byte[1]), 32'hCD);
      check("rd_prefetch4", 32'(tx_byte[3]), 32'h77);
      check("rd_busy_after", 32'(bus.busy), 32'd0);
      check("rd_no_err", 32'(bus.err_timeout), 32'd0);

      // Timeout: cmd 0x83, register file never answers.
      resp_en = 1'b0;
      clear_mon();
      send(8'h83, 1'b1, s0);
      repeat (25) @(negedge clk_40);
      check("to_addr", 32'(re_addr[0]), 32'h03);
      check("to_tx_cycle", 32'(tx_cyc[0] - re_cyc[0]), 32'(TO + 1));
      check("to_tx_data", 32'(tx_byte[0]), 32'hEE);
      check("to_err_set", 32'(bus.err_timeout), 32'd1);
      send(8'h00, 1'b0, s);
      repeat (4) @(negedge clk_40);
      check("to_next_addr", 32'(re_addr[1]), 32'h04);
      end_frame();
      repeat (2) @(negedge clk_40);
      check("to_err_sticky", 32'(bus.err_timeout), 32'd1);

      // Abort: end strobe during RD_WAIT, late rvalid must be ignored.
      resp_en  = 1'b1;
      resp_lat = 6;
      clear_mon();
      send(8'h90, 1'b1, s0);
      @(negedge clk_40);
      end_frame();
      repeat (15) @(negedge clk_40);
      check("ab_one_read", 32'(re_cyc.size()), 32'd1);
      check("ab_no_tx", 32'(tx_cyc.size()), 32'd0);
      check("ab_busy", 32'(bus.busy), 32'd0);
      resp_en = 1'b0;

      // Reset in the middle of a write burst.
      send(8'h05, 1'b1, s);
      @(negedge clk_40);
      bus.rx_data        = 8'h11;
      bus.rx_data_strobe = 1'b1;
      @(posedge clk_40);
      #1;
      check("rst_pre_we", 32'({bus.reg_we, bus.reg_addr, bus.reg_wdata}), 32'({1'b1, 7'h05, 8'h11}));
      @(negedge clk_40);
      bus.rx_data     = 8'h22;
      reset_n         = 1'b0;
      @(posedge clk_40);
      #1;
      check("rst_all_zero", 32'(sample()), 32'(outs_t'(0)));
      @(negedge clk_40);
      bus.rx_data_strobe = 1'b0;
      reset_n            = 1'b1;
      send(8'h33, 1'b1, s);
      @(negedge clk_40);
      bus.rx_data        = 8'h99;
      bus.rx_data_strobe = 1'b1;
      @(posedge clk_40);
      #1;
      check("rst_after_write", 32'(sample()),
            32'(outs_t'{tx_data: 8'h00, tx_strobe: 1'b0, reg_addr: 7'h33, reg_wdata: 8'h99,
                        reg_we: 1'b1, reg_re: 1'b0, busy: 1'b1, err: 1'b0}));
      @(negedge clk_40);
      bus.rx_data_strobe = 1'b0;
      end_frame();
      repeat (2) @(negedge clk_40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_controller.md
# spi_reg_controller

Transaction controller on the byte side of the SPI slave. Parses each chip-select framed SPI transaction into a command byte plus data bytes and sequences register-bus writes or prefetched reads. Feeds read data back to the slave's transmit buffer. Sits between the SPI slave instance and the internal register file, all in the CLK_40 domain.

## Interface
- ADDR_WIDTH, 7: register address width; command byte carries address in bits [ADDR_WIDTH-1:0], ADDR_WIDTH ≤ 7.
- RD_TIMEOUT, 15: maximum CLK_40 cycles from reg_re to reg_rvalid before the read is abandoned.
- CLK_40  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rx_data  input  8  last received byte from SPI slave.
- rx_data_strobe  input  1  one-cycle pulse, rx_data valid.
- rx_start  input  1  high with the first rx_data_strobe of a transaction.
- rx_end_strobe  input  1  one-cycle pulse on CS deassert.
- tx_ready  input  1  slave has consumed its tx buffer.
- tx_data  output  8  next byte for the slave tx buffer.
- tx_data_strobe  output  1  one-cycle load pulse for tx_data.
- reg_addr  output  ADDR_WIDTH  register address.
- reg_wdata  output  8  write data.
- reg_we  output  1  one-cycle write pulse.
- reg_re  output  1  one-cycle read request.
- reg_rdata  input  8  read data, valid with reg_rvalid.
- reg_rvalid  input  1  read completion, ≥1 cycle after reg_re.
- busy  output  1  transaction in progress, from rx_start until rx_end_strobe.
- err_timeout  output  1  sticky; set on read timeout, cleared only by reset.

## Operation
- Protocol: byte0 = {rw, pad, addr}, with rw=1 for read and bit 7 as rw. Later bytes are data, and the address auto-increments modulo 2^ADDR_WIDTH (wrap from max to 0).
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE: on rx_data_strobe with rx_start, latch addr. If rw=0, go to WRITE and pulse tx_data_strobe with tx_data=8'h00. If rw=1, go to RD_ISSUE.
- WRITE: each rx_data_strobe gives reg_we=1, reg_wdata=rx_data and reg_addr=current addr for 1 cycle. The address increments the cycle after.
- RD_ISSUE: pulse reg_re for 1 cycle, then go to RD_WAIT.
- RD_WAIT: on reg_rvalid, tx_data=reg_rdata, pulse tx_data_strobe, increment addr, go to RD_HOLD. After RD_TIMEOUT cycles with no rvalid: tx_data=8'hEE, pulse tx_data_strobe, set err_timeout, increment addr, go to RD_HOLD.
- RD_HOLD: each rx_data_strobe goes to RD_ISSUE, prefetching the next address. The master's data bytes are ignored.
- Read data byte stream: master byte1 returns don't-care (tx buffer preloaded before the command decoded), byte2 returns reg[A], byte3 returns reg[A+1], and so on. Each fetch triggered by byte N's strobe lands in the slave before byte N+1's final-bit SCK rise. This requires read latency + 3 < 8 SCK periods in CLK_40 cycles.
- rx_end_strobe in any state: go to IDLE next cycle and drop busy. A pending read is abandoned; a late reg_rvalid is ignored, with no tx_data_strobe.
- rx_start seen while not in IDLE (missed end strobe): treat as a new command, same as from IDLE.
- rx_end_strobe and rx_data_strobe in the same cycle: end wins, byte discarded.
- Reset (reset_n=0): state=IDLE; tx_data=0, tx_data_strobe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, err_timeout=0. Mid-transaction reset aborts with no further strobes.

## Timing
- Write: reg_we asserted the cycle after rx_data_strobe, registered output; 1-cycle latency.
- Read: reg_re the cycle after entering RD_ISSUE, i.e. 2 cycles after the strobe. tx_data_strobe the cycle after reg_rvalid.
- Timeout counter starts the cycle reg_re is high and fires when count == RD_TIMEOUT.
- busy rises the cycle after the command strobe and falls the cycle after rx_end_strobe.
- All outputs registered; strobes never exceed 1 cycle.

## Structure
- Shared package spi_reg_pkg: state encoding, RW_BIT=7, TX_FILL_WRITE=8'h00, TX_FILL_TIMEOUT=8'hEE.
- No sub-module. A single FSM plus an address counter and a timeout counter; the parent instantiates the SPI slave alongside.

## Test plan
- Write burst: cmd 8'h05, data 8'h11, 8'h22, 8'h33 → reg_we pulses at addr 5/6/7 with 11/22/33, err_timeout=0.
- Read burst, latency 2: regs 0x10=0xAB, 0x11=0xCD; cmd 8'h90, 3 dummy bytes → MISO bytes 1..3 = xx, AB, CD.
- Wrap: write cmd 8'h7F with 2 data bytes → writes at addr 7F then 00.
- Timeout: read cmd 8'h83, rvalid never asserted → after 15 cycles tx_data=EE, strobe, err_timeout=1 sticky.
- Abort: rx_end_strobe during RD_WAIT, then rvalid arrives → no tx_data_strobe, state IDLE, busy=0.
- reset_n low mid-write burst → all outputs 0 next cycle; the next transaction decodes normally.
